minmax_stream_ctrl: RTL and testbench
=====================================

MINMAX_STREAM_CTRL -- requirements
Module: minmax_stream_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 5, meaning element width in bits.
REQ-002 The block SHALL have parameter NI, default 9, meaning block size, i.e. the number of elements per minmax evaluation.
REQ-003 The block SHALL have parameter LW, default 8, meaning the width of the frame-length and global-index fields.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- start, in, 1: frame start pulse.
- len, in, LW: frame length in elements; 0 is illegal.
- us_sel, in, 1: 0 = unsigned, 1 = signed.
- min_max_sel, in, 1: 0 = minimum, 1 = maximum.
- busy, out, 1: high in any state other than IDLE.
- in_valid, in, 1: element valid.
- in_ready, out, 1: element accepted on an in_valid & in_ready cycle.
- in_data, in, W: element value.
- out_valid, out, 1: result valid.
- out_ready, in, 1: result consumed on an out_valid & out_ready cycle.
- result, out, W: winning value.
- index, out, LW: global position of the winner within the frame, 0-based.

Function
REQ-006 The block SHALL implement FSM states IDLE, FILL, CMP and DONE.
REQ-007 In IDLE, a start pulse with len != 0 SHALL latch len, us_sel and min_max_sel, clear the element and slot counters, and move to FILL.
- start with len == 0 is ignored.
- start in any non-IDLE state is ignored.
REQ-008 In FILL, in_ready SHALL be high; each accepted element SHALL be written to block slot s, bits [s*W +: W], and s SHALL increment.
REQ-009 On accepting slot NI-1, or the frame's final element, the FSM SHALL move to CMP; in_ready SHALL be low in CMP, DONE and IDLE.
REQ-010 In CMP, slots not written in the current block SHALL be padded with the neutral value.
- Minimum: the maximum representable value (unsigned 2^W-1, signed 2^(W-1)-1).
- Maximum: the minimum representable value (unsigned 0, signed -2^(W-1)).
REQ-011 In CMP, the registered block SHALL be evaluated by the minmax sub-module.
- Block tie rule: the lowest slot wins.
- Candidate global index = block base + local index.
REQ-012 The running best SHALL be replaced by the candidate only when this is the first block of the frame, or the candidate is strictly better under the latched signedness and direction; equal values keep the earlier (lower) index.
REQ-013 After CMP, the FSM SHALL go to DONE if all len elements are consumed, otherwise to FILL with s = 0 and block base += NI.
REQ-014 In DONE, out_valid SHALL be high and result/index SHALL hold stable until out_ready; on the handshake the FSM SHALL go to IDLE and out_valid SHALL drop on the next cycle.
REQ-015 out_valid SHALL rise on the second rising edge after the edge that accepts the frame's final element.
REQ-016 The global index SHALL be computed at LW bits; len <= 2^LW - 1, so no wrap-around occurs.

Reset
REQ-017 rst SHALL, at any state including mid-frame, force IDLE and clear all partial data:
- busy = 0, in_ready = 0, out_valid = 0.
- result = 0, index = 0.
- all counters, block register and running best = 0.

Configuration
REQ-018 Macro MINMAX_STREAM_ABORT_EN defined: the block SHALL add an input port abort (1 bit).
- abort high in FILL, CMP or DONE forces IDLE on the next edge, with out_valid = 0 and the running best discarded.
- Priority: rst > abort > start.
REQ-019 Macro MINMAX_STREAM_ABORT_EN undefined: the abort port and its logic SHALL be absent, and a frame SHALL only end via DONE or rst.

Structure
REQ-020 Package minmax_pkg SHALL hold:
- the FSM state enum;
- neutral-value functions neutral_min(W, signed) and neutral_max(W, signed);
- localparam IDXW = $clog2(NI).
REQ-021 The block SHALL instantiate the existing combinational minmax module once, with OUT_CFG = 0 and MM_CFG = 0, as its only sub-module.

Verification (W=5, NI=9, LW=8)
REQ-022 Unsigned min, len = 3, data 7, 2, 9 -> result 2, index 1, out_valid two edges after the last accept.
REQ-023 Signed max, len = 12, all elements -8 except element 10 = -1 (5'h1F) -> result 5'h1F, index 10; checks padding of the second block, whose padded slots must not win.
REQ-024 Unsigned max, len = 20, all elements 5 -> result 5, index 0; repeat with signed min -> index 0 (earliest tie wins across blocks).
REQ-025 len = 9, out_ready held low 5 cycles in DONE -> result/index/out_valid stable; start pulses during busy ignored; out_valid clears on the cycle after the handshake.
REQ-026 rst asserted after 4 elements accepted -> next cycle IDLE, busy = 0, in_ready = 0; a new frame afterwards gives correct results with no residue.
REQ-027 With MINMAX_STREAM_ABORT_EN: abort in CMP -> IDLE next cycle, out_valid never rises; start and abort in the same cycle in IDLE -> frame starts.

Source files
------------

// File: rtl/minmax_pkg.sv
// Shared definitions for the streaming min/max controller.
//   state_t      : controller FSM states
//   neutral_min  : pad value for a minimum search (largest representable value)
//   neutral_max  : pad value for a maximum search (smallest representable value)
//   IDXW         : local winner index width for the default block size
// Both neutral functions return a 32-bit word; callers keep the low w bits.
package minmax_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StCmp,
        StDone
    } state_t;

    localparam int unsigned NI_DEFAULT = 9;
    localparam int unsigned IDXW       = $clog2(NI_DEFAULT);

    // Largest value in w bits; a padded slot can never beat a real element in a min search.
    function automatic logic [31:0] neutral_min(input int unsigned w, input logic is_signed);
        logic [31:0] v;
        v = (32'd1 << w) - 32'd1;
        if (is_signed) begin
            v = v >> 1;
        end
        return v;
    endfunction

    // Smallest value in w bits; a padded slot can never beat a real element in a max search.
    function automatic logic [31:0] neutral_max(input int unsigned w, input logic is_signed);
        logic [31:0] v;
        v = '0;
        if (is_signed) begin
            v = 32'd1 << (w - 1);
        end
        return v;
    endfunction

endpackage

// File: rtl/minmax.sv
// Combinational min/max over a block of NI elements packed as data[i*W +: W].
// Ports:
//   data        : NI packed elements, slot 0 in the low bits
//   us_sel      : 0 = unsigned compare, 1 = signed compare
//   min_max_sel : 0 = minimum, 1 = maximum (used when MM_CFG == 0)
//   value       : winning element
//   idx         : slot of the winning element
// Parameters:
//   OUT_CFG : 0 = ties resolve to the lowest slot, otherwise the highest slot
//   MM_CFG  : 0 = direction from min_max_sel, 1 = fixed minimum, 2 = fixed maximum
module minmax #(
    parameter int unsigned W       = 5,
    parameter int unsigned NI      = 9,
    parameter int unsigned IDXW    = minmax_pkg::IDXW,
    parameter int unsigned OUT_CFG = 0,
    parameter int unsigned MM_CFG  = 0
) (
    input  logic [NI*W-1:0] data,
    input  logic            us_sel,
    input  logic            min_max_sel,
    output logic [W-1:0]    value,
    output logic [IDXW-1:0] idx
);

    logic         want_max;
    logic [W-1:0] cand;

    assign want_max = (MM_CFG == 0) ? min_max_sel : (MM_CFG == 2);

    function automatic logic beats(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sgn, input logic mx);
        logic lt;
        logic gt;
        lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
        gt = sgn ? ($signed(a) > $signed(b)) : (a > b);
        return mx ? gt : lt;
    endfunction

    always_comb begin
        value = data[W-1:0];
        idx   = '0;
        cand  = '0;
        for (int i = 1; i < int'(NI); i++) begin
            cand = data[i*W +: W];
            if (beats(cand, value, us_sel, want_max) || (OUT_CFG != 0 && cand == value)) begin
                value = cand;
                idx   = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/minmax_stream_ctrl.sv
// Streaming min/max controller: collects a frame of len elements in blocks of NI,
// evaluates each block with the combinational minmax unit and keeps a running best.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   abort               : frame abort (only with MINMAX_STREAM_ABORT_EN defined)
//   start, len          : frame start pulse and frame length (len == 0 ignored)
//   us_sel, min_max_sel : signed compare / maximum search, latched at start
//   busy                : controller not idle
//   in_valid/in_ready/in_data    : element stream
//   out_valid/out_ready/result/index : result handshake, index is the global position
// Optional feature: define MINMAX_STREAM_ABORT_EN to add the abort input.
module minmax_stream_ctrl
    import minmax_pkg::*;
#(
    parameter int unsigned W  = 5,
    parameter int unsigned NI = 9,
    parameter int unsigned LW = 8
) (
    input  logic          clk,
    input  logic          rst,
`ifdef MINMAX_STREAM_ABORT_EN
    input  logic          abort,
`endif
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic          us_sel,
    input  logic          min_max_sel,
    output logic          busy,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  result,
    output logic [LW-1:0] index
);

    localparam int unsigned SIW = (NI > 1) ? $clog2(NI) : 1;  // local winner index width
    localparam int unsigned SCW = $clog2(NI + 1);             // slot count 0..NI

    localparam logic [SCW-1:0] LAST_SLOT = SCW'(NI - 1);
    localparam logic [LW-1:0]  NI_LW     = LW'(NI);

    state_t          state_q;
    logic            busy_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [LW-1:0]   len_q;
    logic            sgn_q;
    logic            max_q;
    logic [LW-1:0]   cnt_q;       // elements accepted in this frame
    logic [SCW-1:0]  slot_q;      // next free slot in the block
    logic [LW-1:0]   base_q;      // global index of slot 0
    logic [NI*W-1:0] blk_q;
    logic            pad_done_q;  // CMP runs two cycles: pad, then evaluate
    logic            first_q;     // no block evaluated yet in this frame
    logic [W-1:0]    best_val_q;
    logic [LW-1:0]   best_idx_q;

    logic [W-1:0]    mm_val;
    logic [SIW-1:0]  mm_idx;
    logic [W-1:0]    pad_val;
    logic [LW-1:0]   cand_idx;

    function automatic logic beats(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sgn, input logic mx);
        logic lt;
        logic gt;
        lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
        gt = sgn ? ($signed(a) > $signed(b)) : (a > b);
        return mx ? gt : lt;
    endfunction

    minmax #(
        .W       (W),
        .NI      (NI),
        .IDXW    (SIW),
        .OUT_CFG (0),
        .MM_CFG  (0)
    ) u_minmax (
        .data        (blk_q),
        .us_sel      (sgn_q),
        .min_max_sel (max_q),
        .value       (mm_val),
        .idx         (mm_idx)
    );

    always_comb begin
        pad_val  = max_q ? W'(neutral_max(W, sgn_q)) : W'(neutral_min(W, sgn_q));
        cand_idx = base_q + LW'(mm_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            len_q       <= '0;
            sgn_q       <= 1'b0;
            max_q       <= 1'b0;
            cnt_q       <= '0;
            slot_q      <= '0;
            base_q      <= '0;
            blk_q       <= '0;
            pad_done_q  <= 1'b0;
            first_q     <= 1'b0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
`ifdef MINMAX_STREAM_ABORT_EN
        end else if (abort && state_q != StIdle) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            pad_done_q  <= 1'b0;
            first_q     <= 1'b0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && len != '0) begin
                        len_q      <= len;
                        sgn_q      <= us_sel;
                        max_q      <= min_max_sel;
                        cnt_q      <= '0;
                        slot_q     <= '0;
                        base_q     <= '0;
                        first_q    <= 1'b1;
                        pad_done_q <= 1'b0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                        state_q    <= StFill;
                    end
                end
                StFill: begin
                    if (in_valid) begin
                        for (int i = 0; i < int'(NI); i++) begin
                            if (SCW'(i) == slot_q) begin
                                blk_q[i*W +: W] <= in_data;
                            end
                        end
                        slot_q <= slot_q + SCW'(1);
                        cnt_q  <= cnt_q + LW'(1);
                        if (slot_q == LAST_SLOT || cnt_q + LW'(1) == len_q) begin
                            in_ready_q <= 1'b0;
                            pad_done_q <= 1'b0;
                            state_q    <= StCmp;
                        end
                    end
                end
                StCmp: begin
                    if (!pad_done_q) begin
                        // Slots left over from the previous block must not compete.
                        for (int i = 0; i < int'(NI); i++) begin
                            if (SCW'(i) >= slot_q) begin
                                blk_q[i*W +: W] <= pad_val;
                            end
                        end
                        pad_done_q <= 1'b1;
                    end else begin
                        // Strictly-better only, so equal values keep the earlier index.
                        if (first_q || beats(mm_val, best_val_q, sgn_q, max_q)) begin
                            best_val_q <= mm_val;
                            best_idx_q <= cand_idx;
                        end
                        first_q    <= 1'b0;
                        pad_done_q <= 1'b0;
                        if (cnt_q == len_q) begin
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            slot_q     <= '0;
                            base_q     <= base_q + NI_LW;
                            in_ready_q <= 1'b1;
                            state_q    <= StFill;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = best_val_q;
    assign index     = best_idx_q;

endmodule

// File: tb/tb_minmax_stream_ctrl.sv
// Self-checking bench for minmax_stream_ctrl: directed frames with literal expectations
// plus randomized frames, checked against a whole-frame scan model.
module tb_minmax_stream_ctrl;

    localparam int unsigned W  = 5;
    localparam int unsigned NI = 9;
    localparam int unsigned LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          us_sel = 1'b0;
    logic          min_max_sel = 1'b0;
    logic          busy;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result;
    logic [LW-1:0] index;
`ifdef MINMAX_STREAM_ABORT_EN
    logic          abort = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    logic [W-1:0] frame_q[$];
    logic [W-1:0] exp_res = '0;
    int           exp_idx = 0;
    bit           mon_en  = 1'b0;

    always #5 clk = ~clk;

    minmax_stream_ctrl #(
        .W  (W),
        .NI (NI),
        .LW (LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef MINMAX_STREAM_ABORT_EN
        .abort       (abort),
`endif
        .start       (start),
        .len         (len),
        .us_sel      (us_sel),
        .min_max_sel (min_max_sel),
        .busy        (busy),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .index       (index)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit better(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input bit sgn, input bit mx);
        int va;
        int vb;
        va = sgn ? int'($signed(a)) : int'(a);
        vb = sgn ? int'($signed(b)) : int'(b);
        return mx ? (va > vb) : (va < vb);
    endfunction

    // Whole-frame scan: first strictly-better element wins, block structure is irrelevant.
    task automatic model(input int n, input bit sgn, input bit mx);
        exp_res = frame_q[0];
        exp_idx = 0;
        for (int i = 1; i < n; i++) begin
            if (better(frame_q[i], exp_res, sgn, mx)) begin
                exp_res = frame_q[i];
                exp_idx = i;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && out_valid) begin
            chk("mon_result", 32'(result), 32'(exp_res));
            chk("mon_index", 32'(index), exp_idx);
            chk("mon_in_ready_low", 32'(in_ready), 0);
        end
    end

    task automatic start_frame(input int n, input bit sgn, input bit mx);
        model(n, sgn, mx);
        mon_en = 1'b1;
        @(negedge clk);
        start       = 1'b1;
        len         = LW'(n);
        us_sel      = sgn;
        min_max_sel = mx;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_in_ready", 32'(in_ready), 1);
    endtask

    // Feeds frame_q[from..to-1] with random valid gaps and stray start pulses;
    // returns just after the edge that accepts the last element.
    task automatic feed(input int from, input int to);
        int i;
        int guard;
        i = from;
        guard = 0;
        while (i < to && guard < 4000) begin
            @(negedge clk);
            guard++;
            start = ($urandom_range(0, 7) == 0);
            len   = 8'd3;
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = frame_q[i];
            end
            if (in_valid && in_ready) i++;
        end
        if (i < to) chk("feed_timeout", i, to);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic finish_frame(input int hold, input bit has_lit,
                                input logic [W-1:0] lr, input int li);
        @(negedge clk);
        chk("ov_low_edge1", 32'(out_valid), 0);
        @(negedge clk);
        chk("ov_low_edge2", 32'(out_valid), 0);
        @(negedge clk);
        chk("ov_rise", 32'(out_valid), 1);
        if (has_lit) begin
            chk("model_res_lit", 32'(exp_res), 32'(lr));
            chk("model_idx_lit", exp_idx, li);
            chk("dut_res_lit", 32'(result), 32'(lr));
            chk("dut_idx_lit", 32'(index), li);
        end
        for (int k = 0; k < hold; k++) begin
            start = (k == 1);
            len   = 8'd3;
            @(negedge clk);
            chk("hold_ov", 32'(out_valid), 1);
            chk("hold_busy", 32'(busy), 1);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ov_clear", 32'(out_valid), 0);
        chk("busy_clear", 32'(busy), 0);
    endtask

    initial begin
        int n;
        bit sgn;
        bit mx;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_index", 32'(index), 0);
        rst = 1'b0;

        // len == 0 start is ignored
        @(negedge clk);
        start = 1'b1;
        len   = '0;
        @(negedge clk);
        start = 1'b0;
        chk("len0_ignored", 32'(busy), 0);

        // Unsigned min, 7 2 9
        frame_q = {5'd7, 5'd2, 5'd9};
        start_frame(3, 1'b0, 1'b0);
        feed(0, 3);
        finish_frame(0, 1'b1, 5'd2, 1);

        // Signed max over two blocks, padding must not win
        frame_q = {};
        for (int i = 0; i < 12; i++) frame_q.push_back((i == 10) ? 5'h1F : 5'h18);
        start_frame(12, 1'b1, 1'b1);
        feed(0, 12);
        finish_frame(1, 1'b1, 5'h1F, 10);

        // Ties across blocks keep index 0
        frame_q = {};
        for (int i = 0; i < 20; i++) frame_q.push_back(5'd5);
        start_frame(20, 1'b0, 1'b1);
        feed(0, 20);
        finish_frame(0, 1'b1, 5'd5, 0);
        start_frame(20, 1'b1, 1'b0);
        feed(0, 20);
        finish_frame(0, 1'b1, 5'd5, 0);

        // Full block, result held while out_ready is low, start pulses ignored
        frame_q = {};
        for (int i = 0; i < 9; i++) frame_q.push_back(W'($urandom_range(0, 31)));
        start_frame(9, 1'b1, 1'b0);
        feed(0, 9);
        finish_frame(5, 1'b0, '0, 0);

        // Reset mid-frame, then a clean frame
        frame_q = {};
        for (int i = 0; i < 9; i++) frame_q.push_back(5'd1);
        start_frame(9, 1'b0, 1'b0);
        feed(0, 4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_in_ready", 32'(in_ready), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_result", 32'(result), 0);
        chk("midrst_index", 32'(index), 0);
        frame_q = {5'd20, 5'd30, 5'd25, 5'd30};
        start_frame(4, 1'b0, 1'b1);
        feed(0, 4);
        finish_frame(0, 1'b1, 5'd30, 1);

`ifdef MINMAX_STREAM_ABORT_EN
        // Abort while evaluating: no result appears
        frame_q = {5'd4, 5'd1, 5'd6};
        start_frame(3, 1'b0, 1'b0);
        feed(0, 3);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_in_ready", 32'(in_ready), 0);
        chk("abort_result", 32'(result), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_ov", 32'(out_valid), 0);
        end
        // Start wins over abort in IDLE
        frame_q = {5'd3, 5'd12};
        model(2, 1'b0, 1'b1);
        @(negedge clk);
        start       = 1'b1;
        abort       = 1'b1;
        len         = 8'd2;
        us_sel      = 1'b0;
        min_max_sel = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_busy", 32'(busy), 1);
        feed(0, 2);
        finish_frame(1, 1'b1, 5'd12, 1);
`endif

        // Randomized frames
        for (int f = 0; f < 20; f++) begin
            n   = $urandom_range(1, 30);
            sgn = 1'($urandom_range(0, 1));
            mx  = 1'($urandom_range(0, 1));
            frame_q = {};
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 0) frame_q.push_back(W'($urandom_range(0, 31)));
                else frame_q.push_back(W'($urandom_range(14, 17)));
            end
            start_frame(n, sgn, mx);
            feed(0, n);
            finish_frame($urandom_range(0, 3), 1'b0, '0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
